id_decode_stage: RTL and testbench
==================================

Name: id_decode_stage

Overview:
Instruction-decode stage of the 5-stage pipelined processor. It sits between the IF/ID and ID/EX pipeline registers. It decodes the 32-bit instruction held in IF/ID, reads the 32x32 register file and sign-extends the immediate. It generates the EX/MEM/WB control signals and registers everything into the ID/EX pipeline register. It also owns the register-file write port driven by the WB stage.

Parameters:
DATA_W, 32, register and instruction width
PC_W, 8, program-counter width
NREGS, 32, register-file depth (5-bit addresses)

Ports:
clk  in  1  pipeline clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
IF_ID_PC  in  8  PC of the instruction in IF/ID
IF_ID_Instruction  in  32  instruction in IF/ID
RegWrite  in  1  WB write enable
writeReg  in  5  WB destination register
writeData  in  32  WB write data
ID_EX_ReadData1  out  32  reg[rs]
ID_EX_ReadData2  out  32  reg[rt]
ID_EX_SignExtImm  out  32  sign-extended instr[15:0]
ID_EX_Rb  out  5  base/source register, instr[25:21]
ID_EX_Rd  out  5  destination register, after RegDst selection
ID_EX_PC  out  8  PC passed through
ID_EX_RegDst, ID_EX_ALUSrc, ID_EX_MemToReg, ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_Branch  out  1 each  control
ID_EX_ALUOp  out  2  ALU operation class

Behaviour:
- Instruction fields:
  - opcode = [31:26]
  - rs = [25:21]
  - rt = [20:16]
  - rd = [15:11]
  - imm = [15:0]
- Sign extension: SignExtImm = {16{imm[15]}, imm}.
- Control decode (RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, ALUOp):
  - 000000 R-type: 1,0,0,1,0,0,0,10
  - 100011 LW: 0,1,1,1,1,0,0,00
  - 101011 SW: 0,1,0,0,0,1,0,00
  - 000100 BEQ: 0,0,0,0,0,0,1,01
  - 001000 ADDI: 0,1,0,1,0,0,0,00
  - any other opcode: all zero (bubble/NOP).
- Destination select: Rd = RegDst ? rd : rt.
- Register file:
  - 32 x 32 bits.
  - Write on rising clk when RegWrite=1 and writeReg!=0.
  - r0 always reads 0; writes to r0 are ignored.
  - Reads are combinational, with write-through bypass: if RegWrite=1, writeReg!=0 and writeReg equals a read address in the same cycle, that read returns writeData.
- ID/EX register:
  - On rising clk, all ID_EX_* outputs capture their decoded/read values.
  - Latency: an instruction present during cycle n appears on the outputs after edge n+1.
- Reset:
  - When rst=1 at a rising edge, every ID_EX_* output becomes 0 and all 32 registers become 0.
  - The WB write is suppressed in a reset cycle; reset has priority over everything else.
  - Reset asserted mid-stream discards the in-flight instruction, so the outputs form a NOP.
- There is no stall or flush input; the stage advances every cycle.

Test Plan:
- Reset: rst=1 for one edge -> all ID_EX_* = 0. After release, a read of any register returns 0.
- LW decode:
  - Stimulus: write r5=0x00000100 via WB port; then apply IF_ID_Instruction=0x8CA80004, IF_ID_PC=0x04.
  - Next edge: ReadData1=0x100, Rb=5, Rd=8, SignExtImm=0x00000004, PC=0x04.
  - Controls: ALUSrc=1, MemToReg=1, RegWrite=1, MemRead=1, MemWrite=0, Branch=0, ALUOp=00, RegDst=0.
- Negative immediate: instruction 0x8CA8FFFC -> SignExtImm=0xFFFFFFFC, Rd=8.
- R-type: instruction 0x00221820 with r1=7, r2=9 -> ReadData1=7, ReadData2=9, Rd=3, RegDst=1, ALUOp=10, RegWrite=1, ALUSrc=0.
- Bypass and r0:
  - Same cycle: RegWrite=1, writeReg=5, writeData=0xDEADBEEF, decoding rs=5 -> next edge ReadData1=0xDEADBEEF.
  - A write of 0x1234 to r0 -> later reads of r0 return 0.
- Unknown opcode 0x3F / mid-run reset: outputs all-zero control. Asserting rst during an LW zeroes all outputs on that edge.

Source files
------------

// File: rtl/id_decode_stage_if.sv
// Signal bundle between the IF/ID register, the WB write port and the ID/EX register.
// The master side feeds instructions and write-backs; the slave side is the decode stage.
interface id_decode_stage_if #(
   parameter int DATA_W = 32,
   parameter int PC_W   = 8,
   parameter int ADDR_W = 5
);
   logic [PC_W-1:0]   IF_ID_PC;
   logic [DATA_W-1:0] IF_ID_Instruction;
   logic              RegWrite;
   logic [ADDR_W-1:0] writeReg;
   logic [DATA_W-1:0] writeData;

   logic [DATA_W-1:0] ID_EX_ReadData1;
   logic [DATA_W-1:0] ID_EX_ReadData2;
   logic [DATA_W-1:0] ID_EX_SignExtImm;
   logic [ADDR_W-1:0] ID_EX_Rb;
   logic [ADDR_W-1:0] ID_EX_Rd;
   logic [PC_W-1:0]   ID_EX_PC;
   logic              ID_EX_RegDst;
   logic              ID_EX_ALUSrc;
   logic              ID_EX_MemToReg;
   logic              ID_EX_RegWrite;
   logic              ID_EX_MemRead;
   logic              ID_EX_MemWrite;
   logic              ID_EX_Branch;
   logic [1:0]        ID_EX_ALUOp;

   modport master (
      output IF_ID_PC, IF_ID_Instruction, RegWrite, writeReg, writeData,
      input  ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_SignExtImm, ID_EX_Rb, ID_EX_Rd,
             ID_EX_PC, ID_EX_RegDst, ID_EX_ALUSrc, ID_EX_MemToReg, ID_EX_RegWrite,
             ID_EX_MemRead, ID_EX_MemWrite, ID_EX_Branch, ID_EX_ALUOp
   );

   modport slave (
      input  IF_ID_PC, IF_ID_Instruction, RegWrite, writeReg, writeData,
      output ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_SignExtImm, ID_EX_Rb, ID_EX_Rd,
             ID_EX_PC, ID_EX_RegDst, ID_EX_ALUSrc, ID_EX_MemToReg, ID_EX_RegWrite,
             ID_EX_MemRead, ID_EX_MemWrite, ID_EX_Branch, ID_EX_ALUOp
   );
endinterface

// File: rtl/id_decode_stage.sv
// Instruction-decode stage: field decode, register file with WB write-through,
// immediate sign extension, control generation and the ID/EX pipeline register.
module id_decode_stage #(
   parameter int DATA_W = 32,
   parameter int PC_W   = 8,
   parameter int NREGS  = 32
) (
   input logic               clk,
   input logic               rst,
   id_decode_stage_if.slave  pipe_io
);
   localparam int AW = $clog2(NREGS);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   typedef struct packed {
      logic       regDst;
      logic       aluSrc;
      logic       memToReg;
      logic       regWrite;
      logic       memRead;
      logic       memWrite;
      logic       branch;
      logic [1:0] aluOp;
   } ctrl_t;

   typedef struct packed {
      logic [DATA_W-1:0] readData1;
      logic [DATA_W-1:0] readData2;
      logic [DATA_W-1:0] signExtImm;
      logic [AW-1:0]     rb;
      logic [AW-1:0]     rd;
      logic [PC_W-1:0]   pc;
      ctrl_t             ctrl;
   } idex_t;

   logic [DATA_W-1:0] regs_q [NREGS];

   logic [5:0]        opcode;
   logic [AW-1:0]     rsAddr;
   logic [AW-1:0]     rtAddr;
   logic [AW-1:0]     rdAddr;
   logic [15:0]       imm;
   logic              wbEn;
   logic [DATA_W-1:0] rsData;
   logic [DATA_W-1:0] rtData;
   ctrl_t             ctrl;
   idex_t             idex_d;
   idex_t             idex_q;

   assign opcode = pipe_io.IF_ID_Instruction[31:26];
   assign rsAddr = pipe_io.IF_ID_Instruction[25:21];
   assign rtAddr = pipe_io.IF_ID_Instruction[20:16];
   assign rdAddr = pipe_io.IF_ID_Instruction[15:11];
   assign imm    = pipe_io.IF_ID_Instruction[15:0];

   // r0 is hardwired to zero, so a write-back aimed at it is dropped entirely.
   assign wbEn = pipe_io.RegWrite && (pipe_io.writeReg != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wbEn) begin
         regs_q[pipe_io.writeReg] <= pipe_io.writeData;
      end
   end

   // Write-through lets an instruction in ID see the value WB is writing this cycle.
   always_comb begin
      rsData = regs_q[rsAddr];
      if (rsAddr == '0) begin
         rsData = '0;
      end else if (wbEn && (pipe_io.writeReg == rsAddr)) begin
         rsData = pipe_io.writeData;
      end
   end

   always_comb begin
      rtData = regs_q[rtAddr];
      if (rtAddr == '0) begin
         rtData = '0;
      end else if (wbEn && (pipe_io.writeReg == rtAddr)) begin
         rtData = pipe_io.writeData;
      end
   end

   always_comb begin
      ctrl = '0;
      unique case (opcode)
         OP_RTYPE: ctrl = '{regDst: 1'b1, aluSrc: 1'b0, memToReg: 1'b0, regWrite: 1'b1,
                            memRead: 1'b0, memWrite: 1'b0, branch: 1'b0, aluOp: 2'b10};
         OP_LW:    ctrl = '{regDst: 1'b0, aluSrc: 1'b1, memToReg: 1'b1, regWrite: 1'b1,
                            memRead: 1'b1, memWrite: 1'b0, branch: 1'b0, aluOp: 2'b00};
         OP_SW:    ctrl = '{regDst: 1'b0, aluSrc: 1'b1, memToReg: 1'b0, regWrite: 1'b0,
                            memRead: 1'b0, memWrite: 1'b1, branch: 1'b0, aluOp: 2'b00};
         OP_BEQ:   ctrl = '{regDst: 1'b0, aluSrc: 1'b0, memToReg: 1'b0, regWrite: 1'b0,
                            memRead: 1'b0, memWrite: 1'b0, branch: 1'b1, aluOp: 2'b01};
         OP_ADDI:  ctrl = '{regDst: 1'b0, aluSrc: 1'b1, memToReg: 1'b0, regWrite: 1'b1,
                            memRead: 1'b0, memWrite: 1'b0, branch: 1'b0, aluOp: 2'b00};
         default:  ctrl = '0;
      endcase
   end

   always_comb begin
      idex_d            = '0;
      idex_d.readData1  = rsData;
      idex_d.readData2  = rtData;
      idex_d.signExtImm = {{(DATA_W-16){imm[15]}}, imm};
      idex_d.rb         = rsAddr;
      idex_d.rd         = ctrl.regDst ? rdAddr : rtAddr;
      idex_d.pc         = pipe_io.IF_ID_PC;
      idex_d.ctrl       = ctrl;
   end

   // Reset squashes the in-flight instruction so EX sees a NOP.
   always_ff @(posedge clk) begin
      if (rst) begin
         idex_q <= '0;
      end else begin
         idex_q <= idex_d;
      end
   end

   assign pipe_io.ID_EX_ReadData1  = idex_q.readData1;
   assign pipe_io.ID_EX_ReadData2  = idex_q.readData2;
   assign pipe_io.ID_EX_SignExtImm = idex_q.signExtImm;
   assign pipe_io.ID_EX_Rb         = idex_q.rb;
   assign pipe_io.ID_EX_Rd         = idex_q.rd;
   assign pipe_io.ID_EX_PC         = idex_q.pc;
   assign pipe_io.ID_EX_RegDst     = idex_q.ctrl.regDst;
   assign pipe_io.ID_EX_ALUSrc     = idex_q.ctrl.aluSrc;
   assign pipe_io.ID_EX_MemToReg   = idex_q.ctrl.memToReg;
   assign pipe_io.ID_EX_RegWrite   = idex_q.ctrl.regWrite;
   assign pipe_io.ID_EX_MemRead    = idex_q.ctrl.memRead;
   assign pipe_io.ID_EX_MemWrite   = idex_q.ctrl.memWrite;
   assign pipe_io.ID_EX_Branch     = idex_q.ctrl.branch;
   assign pipe_io.ID_EX_ALUOp      = idex_q.ctrl.aluOp;
endmodule

// File: tb/tb_id_decode_stage.sv
// Directed self-checking bench for id_decode_stage: decode, register file,
// write-through bypass, r0 handling and synchronous reset.
module tb_id_decode_stage;
   logic clk;
   logic rst;
   int   checkCount;
   int   passCount;

   id_decode_stage_if #(.DATA_W(32), .PC_W(8), .ADDR_W(5)) bus ();

   id_decode_stage #(.DATA_W(32), .PC_W(8), .NREGS(32)) dut (
      .clk     (clk),
      .rst     (rst),
      .pipe_io (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Control word order: RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, ALUOp[1:0]
   function automatic logic [8:0] ctrlWord();
      return {bus.ID_EX_RegDst, bus.ID_EX_ALUSrc, bus.ID_EX_MemToReg, bus.ID_EX_RegWrite,
              bus.ID_EX_MemRead, bus.ID_EX_MemWrite, bus.ID_EX_Branch, bus.ID_EX_ALUOp};
   endfunction

   task automatic applyStimulus(input logic r, input logic [31:0] instr, input logic [7:0] pc,
                                input logic we, input logic [4:0] wreg, input logic [31:0] wdata);
      @(negedge clk);
      rst                   = r;
      bus.IF_ID_Instruction = instr;
      bus.IF_ID_PC          = pc;
      bus.RegWrite          = we;
      bus.writeReg          = wreg;
      bus.writeData         = wdata;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_rd1"}, bus.ID_EX_ReadData1, 32'h0);
      checkOutput({tag, "_rd2"}, bus.ID_EX_ReadData2, 32'h0);
      checkOutput({tag, "_imm"}, bus.ID_EX_SignExtImm, 32'h0);
      checkOutput({tag, "_rb"}, {27'h0, bus.ID_EX_Rb}, 32'h0);
      checkOutput({tag, "_rdst"}, {27'h0, bus.ID_EX_Rd}, 32'h0);
      checkOutput({tag, "_pc"}, {24'h0, bus.ID_EX_PC}, 32'h0);
      checkOutput({tag, "_ctrl"}, {23'h0, ctrlWord()}, 32'h0);
   endtask

   initial begin
      checkCount = 0;
      passCount  = 0;

      // Reset with a pending WB write to r5 that must be suppressed
      applyStimulus(1'b1, 32'h8CA80004, 8'h04, 1'b1, 5'd5, 32'h0000AAAA);
      checkAllZero("reset");

      // R-type reading r5/r6 after reset: both must be zero
      applyStimulus(1'b0, 32'h00A63820, 8'h01, 1'b0, 5'd0, 32'h0);
      checkOutput("post_reset_r5", bus.ID_EX_ReadData1, 32'h0);
      checkOutput("post_reset_r6", bus.ID_EX_ReadData2, 32'h0);
      checkOutput("post_reset_rd", {27'h0, bus.ID_EX_Rd}, 32'd7);

      // Unknown opcode while writing r5=0x100
      applyStimulus(1'b0, 32'hFC000000, 8'h02, 1'b1, 5'd5, 32'h00000100);
      checkOutput("unknown_ctrl", {23'h0, ctrlWord()}, 32'h0);
      checkOutput("unknown_pc", {24'h0, bus.ID_EX_PC}, 32'h02);

      applyStimulus(1'b0, 32'hFC000000, 8'h03, 1'b1, 5'd1, 32'h00000007);
      applyStimulus(1'b0, 32'hFC000000, 8'h03, 1'b1, 5'd2, 32'h00000009);

      // LW r8, 4(r5)
      applyStimulus(1'b0, 32'h8CA80004, 8'h04, 1'b0, 5'd0, 32'h0);
      checkOutput("lw_rd1", bus.ID_EX_ReadData1, 32'h00000100);
      checkOutput("lw_rb", {27'h0, bus.ID_EX_Rb}, 32'd5);
      checkOutput("lw_rd", {27'h0, bus.ID_EX_Rd}, 32'd8);
      checkOutput("lw_imm", bus.ID_EX_SignExtImm, 32'h00000004);
      checkOutput("lw_pc", {24'h0, bus.ID_EX_PC}, 32'h04);
      checkOutput("lw_ctrl", {23'h0, ctrlWord()}, {23'h0, 9'b011110000});

      // Negative immediate
      applyStimulus(1'b0, 32'h8CA8FFFC, 8'h05, 1'b0, 5'd0, 32'h0);
      checkOutput("neg_imm", bus.ID_EX_SignExtImm, 32'hFFFFFFFC);
      checkOutput("neg_rd", {27'h0, bus.ID_EX_Rd}, 32'd8);

      // R-type add r3, r1, r2
      applyStimulus(1'b0, 32'h00221820, 8'h06, 1'b0, 5'd0, 32'h0);
      checkOutput("r_rd1", bus.ID_EX_ReadData1, 32'd7);
      checkOutput("r_rd2", bus.ID_EX_ReadData2, 32'd9);
      checkOutput("r_rd", {27'h0, bus.ID_EX_Rd}, 32'd3);
      checkOutput("r_ctrl", {23'h0, ctrlWord()}, {23'h0, 9'b100100010});

      // SW r5, 8(r5) with same-cycle write of r5: both read ports bypass
      applyStimulus(1'b0, 32'hACA50008, 8'h07, 1'b1, 5'd5, 32'hDEADBEEF);
      checkOutput("byp_rd1", bus.ID_EX_ReadData1, 32'hDEADBEEF);
      checkOutput("byp_rd2", bus.ID_EX_ReadData2, 32'hDEADBEEF);
      checkOutput("sw_rd", {27'h0, bus.ID_EX_Rd}, 32'd5);
      checkOutput("sw_ctrl", {23'h0, ctrlWord()}, {23'h0, 9'b010001000});

      // The bypassed write must also have landed in r5
      applyStimulus(1'b0, 32'h8CA80004, 8'h08, 1'b0, 5'd0, 32'h0);
      checkOutput("r5_stored", bus.ID_EX_ReadData1, 32'hDEADBEEF);

      // BEQ r0, r0 while attempting to write r0 = 0x1234
      applyStimulus(1'b0, 32'h10000003, 8'h09, 1'b1, 5'd0, 32'h00001234);
      checkOutput("r0_nobyp", bus.ID_EX_ReadData1, 32'h0);
      checkOutput("beq_ctrl", {23'h0, ctrlWord()}, {23'h0, 9'b000000101});
      checkOutput("beq_imm", bus.ID_EX_SignExtImm, 32'h00000003);

      applyStimulus(1'b0, 32'h10000003, 8'h0A, 1'b0, 5'd0, 32'h0);
      checkOutput("r0_later", bus.ID_EX_ReadData1, 32'h0);

      // ADDI r2, r1, -1
      applyStimulus(1'b0, 32'h2022FFFF, 8'h0B, 1'b0, 5'd0, 32'h0);
      checkOutput("addi_rd1", bus.ID_EX_ReadData1, 32'd7);
      checkOutput("addi_imm", bus.ID_EX_SignExtImm, 32'hFFFFFFFF);
      checkOutput("addi_rd", {27'h0, bus.ID_EX_Rd}, 32'd2);
      checkOutput("addi_ctrl", {23'h0, ctrlWord()}, {23'h0, 9'b010100000});

      // Reset during an LW with a WB write to r1 pending
      applyStimulus(1'b1, 32'h8CA80004, 8'h0C, 1'b1, 5'd1, 32'h00000055);
      checkAllZero("midreset");

      // Registers cleared and the reset-cycle write suppressed
      applyStimulus(1'b0, 32'h00A10020, 8'h0D, 1'b0, 5'd0, 32'h0);
      checkOutput("cleared_r5", bus.ID_EX_ReadData1, 32'h0);
      checkOutput("cleared_r1", bus.ID_EX_ReadData2, 32'h0);
      checkOutput("cleared_pc", {24'h0, bus.ID_EX_PC}, 32'h0D);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule
